// File: rtl/adc_pulse_sampler_if.sv
// Sample-stream and result bundle between the experiment controller and one
// ADC pulse sampler channel.
interface adc_pulse_sampler_if #(
    parameter int NUM_BITS = 16,
    parameter int DEL_W    = 16
);
    logic [NUM_BITS-1:0] adc_tdata;
    logic                adc_tvalid;
    logic                run;
    logic                abort;
    logic                bypass;
    logic [DEL_W-1:0]    del_cfg;
    logic [2:0]          avg_log2;
    logic [NUM_BITS-1:0] val_out;
    logic                val_valid;
    logic                busy;

    modport master (
        output adc_tdata, adc_tvalid, run, abort, bypass, del_cfg, avg_log2,
        input  val_out, val_valid, busy
    );

    modport slave (
        input  adc_tdata, adc_tvalid, run, abort, bypass, del_cfg, avg_log2,
        output val_out, val_valid, busy
    );
endinterface

// File: rtl/adc_pulse_sampler.sv
// Skips a programmable number of ADC samples after run, averages 2^k samples
// and emits one result strobe; bypass mode streams samples straight through.
module adc_pulse_sampler #(
    parameter int NUM_BITS = 16,
    parameter int DEL_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    adc_pulse_sampler_if.slave  bus
);
    localparam int ACC_W = NUM_BITS + 7;

    typedef enum logic [1:0] {IDLE, DELAY, ACCUM, OUT} state_t;

    state_t                     state_reg,     state_next;
    logic [DEL_W-1:0]           del_cnt_reg,   del_cnt_next;
    logic [7:0]                 smp_cnt_reg,   smp_cnt_next;
    logic [2:0]                 k_reg,         k_next;
    logic signed [ACC_W-1:0]    acc_reg,       acc_next;
    logic [NUM_BITS-1:0]        val_out_reg,   val_out_next;
    logic                       val_valid_reg, val_valid_next;

    logic signed [ACC_W-1:0]    sample_ext;
    logic [NUM_BITS-1:0]        shifted [8];

    assign sample_ext = {{7{bus.adc_tdata[NUM_BITS-1]}}, bus.adc_tdata};

    // The average of 2^k samples always fits NUM_BITS, so acc >>> k is exactly
    // the NUM_BITS-wide window starting at bit k (floor rounding for negatives).
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_shift
            assign shifted[gi] = acc_reg[gi +: NUM_BITS];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            del_cnt_reg   <= '0;
            smp_cnt_reg   <= '0;
            k_reg         <= '0;
            acc_reg       <= '0;
            val_out_reg   <= '0;
            val_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            del_cnt_reg   <= del_cnt_next;
            smp_cnt_reg   <= smp_cnt_next;
            k_reg         <= k_next;
            acc_reg       <= acc_next;
            val_out_reg   <= val_out_next;
            val_valid_reg <= val_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        del_cnt_next   = del_cnt_reg;
        smp_cnt_next   = smp_cnt_reg;
        k_next         = k_reg;
        acc_next       = acc_reg;
        val_out_next   = val_out_reg;
        val_valid_next = 1'b0;

        if (bus.abort) begin
            state_next   = IDLE;
            del_cnt_next = '0;
            smp_cnt_next = '0;
            acc_next     = '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (bus.bypass) begin
                        val_out_next   = bus.adc_tdata;
                        val_valid_next = bus.adc_tvalid;
                    end else if (bus.run) begin
                        del_cnt_next = bus.del_cfg;
                        k_next       = bus.avg_log2;
                        acc_next     = '0;
                        smp_cnt_next = 8'd1 << bus.avg_log2;
                        state_next   = (bus.del_cfg == '0) ? ACCUM : DELAY;
                    end
                end
                DELAY: begin
                    if (bus.adc_tvalid) begin
                        del_cnt_next = del_cnt_reg - DEL_W'(1);
                        if (del_cnt_reg == DEL_W'(1)) begin
                            state_next = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.adc_tvalid) begin
                        acc_next     = acc_reg + sample_ext;
                        smp_cnt_next = smp_cnt_reg - 8'd1;
                        if (smp_cnt_reg == 8'd1) begin
                            state_next = OUT;
                        end
                    end
                end
                OUT: begin
                    val_out_next   = shifted[k_reg];
                    val_valid_next = 1'b1;
                    state_next     = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.val_out   = val_out_reg;
    assign bus.val_valid = val_valid_reg;
    assign bus.busy      = (state_reg != IDLE);
endmodule
